// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline-side signals of the hazard/flush controller.
//   Hazard inputs  : IFID_opcode, IFID_rs1, IFID_rs2, IDEX_MemRead, IDEX_rd,
//                    EX_Redirect, mem_busy
//   Enable outputs : PCWrite, IFID_Write, IFID_Flush, Control_Flush,
//                    IDEX_Write, EXMEM_Write, MEMWB_Bubble, PCRedirect
// The master modport is the pipeline datapath, which supplies hazard
// information and obeys the enables. The slave modport is the controller.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [6:0] IFID_opcode;
    logic [4:0] IFID_rs1;
    logic [4:0] IFID_rs2;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_rd;
    logic       EX_Redirect;
    logic       mem_busy;

    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       Control_Flush;
    logic       IDEX_Write;
    logic       EXMEM_Write;
    logic       MEMWB_Bubble;
    logic       PCRedirect;

    modport master (
        output IFID_opcode, IFID_rs1, IFID_rs2, IDEX_MemRead, IDEX_rd,
               EX_Redirect, mem_busy,
        input  PCWrite, IFID_Write, IFID_Flush, Control_Flush,
               IDEX_Write, EXMEM_Write, MEMWB_Bubble, PCRedirect
    );

    modport slave (
        input  IFID_opcode, IFID_rs1, IFID_rs2, IDEX_MemRead, IDEX_rd,
               EX_Redirect, mem_busy,
        output PCWrite, IFID_Write, IFID_Flush, Control_Flush,
               IDEX_Write, EXMEM_Write, MEMWB_Bubble, PCRedirect
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard and flush controller for the five-stage RISC-V core.
// Each cycle it decides whether the PC and the pipeline registers advance,
// hold or are bubbled. It handles load-use hazards, EX-stage redirects
// followed by an IMEM refill window, and data-memory wait states.
//   clk          : core clock, all state updates on the rising edge
//   rst          : synchronous active-high reset
//   bus          : hazard inputs and register enables (slave side)
//   stall_cycles : number of non-reset cycles with PCWrite low
//   flush_events : number of accepted redirects
// IMEM_LAT (0..7) is the number of extra cycles IF/ID stays flushed after a
// redirect, which covers the read latency of the synchronous IMEM.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int IMEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic {RUN, REFILL} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] rcnt;
    logic [2:0] rcnt_next;

    logic uses_rs1;
    logic uses_rs2;
    logic load_use;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic control_flush;
    logic idex_write;
    logic exmem_write;
    logic memwb_bubble;
    logic pc_redirect;

    // Opcodes that actually read rs1/rs2. For the others the register
    // fields hold immediate bits, so a match must not cause a stall.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (bus.IFID_opcode)
            7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            7'b0000011: uses_rs1 = 1'b1;
            7'b0010011: uses_rs1 = 1'b1;
            7'b1100111: uses_rs1 = 1'b1;
            default: begin uses_rs1 = 1'b0; uses_rs2 = 1'b0; end
        endcase
    end

    assign load_use = bus.IDEX_MemRead && (bus.IDEX_rd != 5'd0) &&
                      ((uses_rs1 && (bus.IDEX_rd == bus.IFID_rs1)) ||
                       (uses_rs2 && (bus.IDEX_rd == bus.IFID_rs2)));

    // Output enables and next FSM state, in priority order.
    // While memory is busy the whole pipe is frozen, so a redirect coming
    // from EX stays asserted and is taken once the wait ends.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        control_flush = 1'b0;
        idex_write    = 1'b1;
        exmem_write   = 1'b1;
        memwb_bubble  = 1'b0;
        pc_redirect   = 1'b0;
        state_next    = state;
        rcnt_next     = rcnt;

        if (rst) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            control_flush = 1'b1;
            memwb_bubble  = 1'b1;
            state_next    = RUN;
            rcnt_next     = 3'd0;
        end else if (bus.mem_busy) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            exmem_write   = 1'b0;
            memwb_bubble  = 1'b1;
        end else if (bus.EX_Redirect) begin
            pc_redirect   = 1'b1;
            ifid_flush    = 1'b1;
            control_flush = 1'b1;
            rcnt_next     = 3'(IMEM_LAT);
            state_next    = (IMEM_LAT > 0) ? REFILL : RUN;
        end else if (state == REFILL) begin
            ifid_flush    = 1'b1;
            control_flush = 1'b1;
            rcnt_next     = rcnt - 3'd1;
            if (rcnt == 3'd1) begin
                state_next = RUN;
            end
        end else if (load_use) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            control_flush = 1'b1;
        end
    end

    // FSM state plus the performance counters. The counters record each
    // event on the edge that closes the cycle in which it happened.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            rcnt         <= 3'd0;
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
            if (!pc_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (pc_redirect) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.IFID_Write    = ifid_write;
    assign bus.IFID_Flush    = ifid_flush;
    assign bus.Control_Flush = control_flush;
    assign bus.IDEX_Write    = idex_write;
    assign bus.EXMEM_Write   = exmem_write;
    assign bus.MEMWB_Bubble  = memwb_bubble;
    assign bus.PCRedirect    = pc_redirect;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives three hazard_ctrl instances (IMEM_LAT = 0, 1, 3) with identical
// inputs and compares their enables and counters against a reference
// model that tracks the number of remaining flush slots and the event
// counts directly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       memRead;
    logic [4:0] rd;
    logic       redirect;
    logic       busy;

    logic [7:0]  obsOut[3];
    logic [31:0] obsStall[3];
    logic [31:0] obsFlush[3];

    int totalChecks;
    int badChecks;

    // Reference model state per instance: flush slots still owed after a
    // redirect, and the expected counter values.
    int          refLeft[3];
    logic [31:0] refStall[3];
    logic [31:0] refFlush[3];

    hazard_ctrl_if bus[3] ();

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [31:0] stallW;
        logic [31:0] flushW;

        assign bus[g].IFID_opcode  = opcode;
        assign bus[g].IFID_rs1     = rs1;
        assign bus[g].IFID_rs2     = rs2;
        assign bus[g].IDEX_MemRead = memRead;
        assign bus[g].IDEX_rd      = rd;
        assign bus[g].EX_Redirect  = redirect;
        assign bus[g].mem_busy     = busy;

        hazard_ctrl #(.IMEM_LAT(LAT)) dut (
            .clk          (clk),
            .rst          (rst),
            .bus          (bus[g]),
            .stall_cycles (stallW),
            .flush_events (flushW)
        );

        assign obsOut[g] = {bus[g].PCWrite, bus[g].IFID_Write,
                            bus[g].IFID_Flush, bus[g].Control_Flush,
                            bus[g].IDEX_Write, bus[g].EXMEM_Write,
                            bus[g].MEMWB_Bubble, bus[g].PCRedirect};
        assign obsStall[g] = stallW;
        assign obsFlush[g] = flushW;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int latOf(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // Hazard rule from the ISA's point of view: which formats read rs1/rs2.
    function automatic bit refLoadUse();
        bit r1;
        bit r2;
        r1 = opcode inside {OP_R, OP_LOAD, OP_I, OP_S, OP_B, OP_JALR};
        r2 = opcode inside {OP_R, OP_S, OP_B};
        return memRead && (rd != 0) &&
               ((r1 && rd == rs1) || (r2 && rd == rs2));
    endfunction

    // Expected enable vector, bit order:
    // PCWrite IFID_Write IFID_Flush Control_Flush IDEX_Write EXMEM_Write
    // MEMWB_Bubble PCRedirect
    function automatic logic [7:0] refOut(input int k);
        if (rst)              return 8'b0011_1110;
        if (busy)             return 8'b0000_0010;
        if (redirect)         return 8'b1111_1101;
        if (refLeft[k] > 0)   return 8'b1111_1100;
        if (refLoadUse())     return 8'b0001_1100;
        return 8'b1100_1100;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model away from
    // the rising edge, then advance the model across the edge.
    task automatic applyStimulus(input logic r, input logic [6:0] op,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic mr, input logic [4:0] d,
                                 input logic rdr, input logic bsy);
        @(negedge clk);
        rst = r; opcode = op; rs1 = s1; rs2 = s2;
        memRead = mr; rd = d; redirect = rdr; busy = bsy;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("out_lat%0d", latOf(k)), 32'(obsOut[k]),
                        32'(refOut(k)));
            checkOutput($sformatf("stall_lat%0d", latOf(k)), obsStall[k],
                        refStall[k]);
            checkOutput($sformatf("flush_lat%0d", latOf(k)), obsFlush[k],
                        refFlush[k]);
        end
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                refLeft[k]  = 0;
                refStall[k] = 0;
                refFlush[k] = 0;
            end else if (busy) begin
                refStall[k] = refStall[k] + 1;
            end else if (redirect) begin
                refFlush[k] = refFlush[k] + 1;
                refLeft[k]  = latOf(k);
            end else if (refLeft[k] > 0) begin
                refLeft[k] = refLeft[k] - 1;
            end else if (refLoadUse()) begin
                refStall[k] = refStall[k] + 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        applyStimulus(1'b1, OP_I, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    logic [6:0] opTable[10];

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        rst = 1'b1; opcode = 7'd0; rs1 = 5'd0; rs2 = 5'd0;
        memRead = 1'b0; rd = 5'd0; redirect = 1'b0; busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            refLeft[k] = 0; refStall[k] = 0; refFlush[k] = 0;
        end
        opTable = '{OP_R, OP_LOAD, OP_I, OP_S, OP_B, OP_JALR,
                    OP_LUI, OP_AUI, OP_JAL, 7'b0000000};
        repeat (2) @(posedge clk);

        $display("[TB] reset");
        repeat (3) applyStimulus(1'b1, OP_R, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
        idle(1);

        $display("[TB] load-use and false-stall cases");
        applyStimulus(1'b0, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, OP_R, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 checkOutput("lu_stall", obsStall[1], 32'd1);
        applyStimulus(1'b0, OP_R, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, OP_LUI, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, OP_I, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, OP_LOAD, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        #1 checkOutput("nofalse_stall", obsStall[1], 32'd2);

        $display("[TB] redirect");
        pulseReset();
        applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        idle(4);
        #1 checkOutput("redir_flush", obsFlush[1], 32'd1);

        $display("[TB] memory wait with pending redirect");
        pulseReset();
        applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (3)
            applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(4);
        #1 checkOutput("wait_stall", obsStall[2], 32'd4);

        $display("[TB] back-to-back redirects");
        pulseReset();
        applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, OP_I, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(5);
        #1 checkOutput("b2b_flush", obsFlush[2], 32'd2);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          opTable[$urandom_range(0, 9)],
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 15);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
